// File: rtl/bcd_stopwatch_ctrl.sv
// Prescaled start/stop/pause sequencer driving a synchronous BCD digit chain.
// Optional lap capture register is built when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  zero,
`ifdef STOPWATCH_LAP_EN
  input  logic                  lap,
`endif
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  tick,
  output logic                  overflow
`ifdef STOPWATCH_LAP_EN
  ,
  output logic [4*DIGITS-1:0]   lap_digits
`endif
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   inc_digits_c;
  logic            all_nines_c;
  logic            last_c;
  logic            carry_c;
  logic [3:0]      digit_c;

  // Synchronous carry: every digit sees "all lower digits are 9" in the same cycle.
  always_comb begin
    inc_digits_c = digits;
    carry_c      = 1'b1;
    digit_c      = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit_c = digits[4*i +: 4];
      if (carry_c) inc_digits_c[4*i +: 4] = (digit_c == 4'd9) ? 4'd0 : digit_c + 4'd1;
      carry_c = carry_c && (digit_c == 4'd9);
    end
    all_nines_c = carry_c;
  end

  assign last_c   = (presc == PW'(PRESCALE - 1));
  assign running  = (state == RUN);
  assign overflow = (state == OVF);

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      presc      <= '0;
      digits     <= '0;
      tick       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_digits <= '0;
`endif
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (zero) begin
            digits <= '0;
            presc  <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_digits <= '0;
`endif
          end
          if (start && !stop) begin
            state <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          if (last_c) begin
            presc <= '0;
            if (!all_nines_c) begin
              digits <= inc_digits_c;
              tick   <= 1'b1;
            end
          end else if (!stop) begin
            presc <= presc + PW'(1);
          end
          // Overflow wins over a coincident stop: the count is already saturated.
          if (last_c && all_nines_c) state <= OVF;
          else if (stop)             state <= PAUSE;
`ifdef STOPWATCH_LAP_EN
          if (lap) lap_digits <= (last_c && !all_nines_c) ? inc_digits_c : digits;
`endif
        end
        PAUSE: begin
          if (zero) begin
            state  <= IDLE;
            digits <= '0;
            presc  <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_digits <= '0;
`endif
          end else if (start && !stop) begin
            state <= RUN;
          end
        end
        OVF: begin
          if (zero) begin
            state  <= IDLE;
            digits <= '0;
            presc  <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_digits <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a 4-digit/PRESCALE=10 instance for timing and carries,
// and a 2-digit/PRESCALE=1 instance for table vectors and overflow.
module tb_bcd_stopwatch_ctrl;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, start, stop, zero;
  logic [15:0] digits;
  logic        running, tick, overflow;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
  logic [15:0] lap_digits;
`endif

  logic        s_clear, s_start, s_stop, s_zero;
  logic [7:0]  s_digits;
  logic        s_running, s_tick, s_overflow;
`ifdef STOPWATCH_LAP_EN
  logic        s_lap;
  logic [7:0]  s_lap_digits;
`endif

  bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(10)) u_main (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .zero(zero),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_digits(lap_digits),
`endif
    .digits(digits), .running(running), .tick(tick), .overflow(overflow)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(1)) u_small (
    .clock(clock), .clear(s_clear), .start(s_start), .stop(s_stop), .zero(s_zero),
`ifdef STOPWATCH_LAP_EN
    .lap(s_lap), .lap_digits(s_lap_digits),
`endif
    .digits(s_digits), .running(s_running), .tick(s_tick), .overflow(s_overflow)
  );

  typedef struct {
    logic       clr, sta, stp, zer;
    logic [7:0] dig;
    logic       run, tck, ovf;
  } vec_t;

  vec_t vecs[16];
  int   errors = 0;
  int   checks = 0;
  int   cnt    = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Step until the main instance pulses tick; verify value and gap from the previous event.
  task automatic wait_tick(input int exp_gap);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 50) begin
      step();
      n++;
      if (tick) seen = 1;
    end
    if (!seen) begin
      check("tick_timeout", 32'(n), 32'(exp_gap));
    end else begin
      cnt++;
      check("tick_val", 32'(digits), 32'(to_bcd(cnt)));
      if (exp_gap > 0) check("tick_gap", 32'(n), 32'(exp_gap));
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; stop = 1'b0; zero = 1'b0;
    s_clear = 1'b1; s_start = 1'b0; s_stop = 1'b0; s_zero = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0; s_lap = 1'b0;
`endif

    //            clr  sta  stp  zer  dig    run  tck  ovf
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 8'h00, 1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 8'h00, 1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0, 8'h00, 1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0, 8'h00, 1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0, 8'h00, 1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1, 8'h01, 1'b1,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 8'h02, 1'b1,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0, 8'h03, 1'b0,1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 8'h03, 1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0, 8'h03, 1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0, 8'h03, 1'b1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0, 8'h04, 1'b1,1'b1,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1, 8'h05, 1'b1,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b0, 8'h06, 1'b0,1'b1,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b1, 8'h00, 1'b0,1'b0,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0, 8'h00, 1'b0,1'b0,1'b0};

    // Reset and basic count on the 4-digit instance
    step();
    step();
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_running", 32'(running), 32'h1);
    check("start_digits", 32'(digits), 32'h0);
    cnt = 0;
    wait_tick(10);
    wait_tick(10);

    // Carry chain through 0x0010 and 0x0100
    while (cnt < 100) wait_tick(10);
    check("carry_0100", 32'(digits), 32'h0100);

    // Pause with prescaler at 6, hold 20 cycles, resume
    repeat (6) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("pause_running", 32'(running), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("pause_digits", 32'(digits), 32'h0100);
      check("pause_run", 32'(running), 32'h0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_running", 32'(running), 32'h1);
    wait_tick(4);

    // Mid-run clear, then start+stop together in IDLE
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_digits", 32'(digits), 32'h0);
    check("clr_running", 32'(running), 32'h0);
    start = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("idle_startstop_run", 32'(running), 32'h0);
    step();
    start = 1'b0;
    check("restart_running", 32'(running), 32'h1);
    cnt = 0;

`ifdef STOPWATCH_LAP_EN
    while (cnt < 12) wait_tick(10);
    lap = 1'b1;
    step();
    lap = 1'b0;
    check("lap_capture", 32'(lap_digits), 32'h0012);
    wait_tick(9);
    check("lap_hold", 32'(lap_digits), 32'h0012);
    stop = 1'b1;
    step();
    stop = 1'b0;
    lap = 1'b1;
    step();
    lap = 1'b0;
    check("lap_pause_ignored", 32'(lap_digits), 32'h0012);
    check("lap_pause_digits", 32'(digits), 32'h0013);
    zero = 1'b1;
    step();
    zero = 1'b0;
    check("lap_zero_lap", 32'(lap_digits), 32'h0);
    check("lap_zero_digits", 32'(digits), 32'h0);
    check("lap_zero_running", 32'(running), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
`endif

    // zero is ignored while running
    while (cnt < 5) wait_tick(10);
    zero = 1'b1;
    step();
    zero = 1'b0;
    check("run_zero_digits", 32'(digits), 32'(to_bcd(5)));
    check("run_zero_running", 32'(running), 32'h1);
    wait_tick(9);
    while (cnt < 37) wait_tick(10);
    check("at_0037", 32'(digits), 32'h0037);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr37_digits", 32'(digits), 32'h0);
    check("clr37_running", 32'(running), 32'h0);
    check("clr37_tick", 32'(tick), 32'h0);

    // Table vectors on the 2-digit, PRESCALE=1 instance
    for (int i = 0; i < 16; i++) begin
      s_clear = vecs[i].clr;
      s_start = vecs[i].sta;
      s_stop  = vecs[i].stp;
      s_zero  = vecs[i].zer;
      step();
      check($sformatf("vec%0d_digits", i), 32'(s_digits), 32'(vecs[i].dig));
      check($sformatf("vec%0d_running", i), 32'(s_running), 32'(vecs[i].run));
      check($sformatf("vec%0d_tick", i), 32'(s_tick), 32'(vecs[i].tck));
      check($sformatf("vec%0d_overflow", i), 32'(s_overflow), 32'(vecs[i].ovf));
    end
    s_clear = 1'b0;
    s_start = 1'b0;
    s_stop  = 1'b0;
    s_zero  = 1'b0;

    // Overflow: 99 increments, then saturation at the 100th increment edge
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("ovf_start_run", 32'(s_running), 32'h1);
    for (int k = 1; k <= 99; k++) begin
      step();
      check("ovf_count", 32'(s_digits), 32'(to_bcd(k) & 16'h00ff));
      check("ovf_count_tick", 32'(s_tick), 32'h1);
    end
    step();
    check("ovf_digits", 32'(s_digits), 32'h99);
    check("ovf_flag", 32'(s_overflow), 32'h1);
    check("ovf_running", 32'(s_running), 32'h0);
    check("ovf_tick", 32'(s_tick), 32'h0);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_stop = 1'b1;
    step();
    s_stop = 1'b0;
    check("ovf_start_ignored", 32'(s_overflow), 32'h1);
    check("ovf_hold_digits", 32'(s_digits), 32'h99);
    check("ovf_hold_running", 32'(s_running), 32'h0);
    s_zero = 1'b1;
    step();
    s_zero = 1'b0;
    check("ovf_zero_digits", 32'(s_digits), 32'h00);
    check("ovf_zero_flag", 32'(s_overflow), 32'h0);
    check("ovf_zero_running", 32'(s_running), 32'h0);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("ovf_restart_running", 32'(s_running), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Synchronous controller and sequencer for a chain of cascaded decade (BCD) digit counters.
- Prescales `clock` into count ticks and runs a start/stop/pause FSM.
- Drives all digits with synchronous carry, so there is no ripple clocking.
- Sits between front-panel control strobes and the BCD display path, and replaces ripple-clocked decade counters wherever glitch-free multi-digit counts are needed.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8).
- PRESCALE, 10, clock cycles per count tick while running (>=1).

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- clear  input  1  synchronous, active-high reset; dominates every other input.
- start  input  1  level-sampled request to run.
- stop  input  1  level-sampled request to pause.
- zero  input  1  request to zero the count; honoured only when not running.
- digits  output  4*DIGITS  BCD count; digit 0 is bits [3:0] (least significant).
- running  output  1  high while the FSM is in RUN.
- tick  output  1  one-cycle pulse in the cycle `digits` first shows a new value.
- overflow  output  1  sticky; high in OVF state.

Behaviour:
- Reset: `clear` high at an edge forces the following, regardless of other inputs or state:
  - state=IDLE, prescaler=0
  - `digits`=0, `running`=0, `tick`=0, `overflow`=0
- States: IDLE, RUN, PAUSE, OVF. Encoding is free.
- IDLE:
  - `start` -> RUN, prescaler cleared to 0.
  - `zero` -> digits=0 (already 0 after reset).
  - `stop` is ignored.
- RUN:
  - Each edge, prescaler += 1.
  - When prescaler==PRESCALE-1 at an edge: prescaler->0 and the count increments.
  - `stop` -> PAUSE at that edge, holding prescaler and digits. An increment due at the same edge still happens.
  - `zero` and `start` are ignored.
- PAUSE:
  - Prescaler and digits frozen.
  - `start` -> RUN, resuming with the preserved prescaler value.
  - `zero` -> digits=0, prescaler=0, state IDLE.
- Simultaneous inputs:
  - `stop` beats `start` in every state.
  - In PAUSE, `zero` beats `start`.
- Increment rule (all digits update in the same edge):
  - Digit i increments if all lower digits are 9.
  - A digit at 9 that increments becomes 0.
  - Digits never hold 10..15.
- Overflow: an increment when all digits are 9 causes:
  - `digits` to hold at all-9s, with no wrap;
  - state -> OVF, `overflow`=1, `running`=0;
  - no `tick` pulse.
- OVF:
  - Only `zero` (or `clear`) leaves.
  - `zero` -> IDLE, digits=0, `overflow`=0.
  - `start` and `stop` are ignored.
- Latency:
  - `start` sampled at edge E0 -> `running`=1 after E0.
  - First increment occurs at edge E0+PRESCALE (from IDLE).
  - `tick` is high for exactly the cycle after each increment edge.
- PRESCALE=1: increment on every RUN edge; the prescaler register may be optimised away.
- `running` and `overflow` are registered and decode directly from state; no combinational input-to-output paths.

Optional Feature:
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - Adds input `lap` (1 bit) and output `lap_digits` (4*DIGITS).
  - `lap` high at an edge in RUN captures the digit value present after that edge, including a coincident increment, into `lap_digits`.
  - `lap` is ignored in other states.
  - `lap_digits` resets to 0 on `clear` and on `zero`; it is otherwise held.
- Undefined:
  - Neither port exists and no capture register is built.
  - All other behaviour is identical.

Test Plan:
1. Reset and basic count:
   - Stimulus: assert `clear` 2 cycles, then `start` 1 cycle; DIGITS=4, PRESCALE=10.
   - Response: `digits`=0x0000 before; 0x0001 with `tick` high 10 edges after the start edge; 0x0002 10 edges later.
2. Carry chain:
   - Stimulus: run to 0x0009, then one more tick; continue to 0x0099 and one more tick.
   - Response: 0x0010 with a single `tick`; then 0x0100, all digits updating at one edge.
3. Pause/resume:
   - Stimulus: `stop` when prescaler=6; wait 20 cycles; `start`.
   - Response: `digits` frozen and `running`=0 during the wait; the next increment arrives 4 edges after the resume edge.
4. Overflow:
   - Stimulus: DIGITS=2, PRESCALE=1; run from 00.
   - Response: `digits`=0x99 holds; `overflow`=1 and `running`=0 after the 100th increment edge; `start` ignored; `zero` -> 0x00, `overflow`=0, IDLE.
5. Precedence and mid-run reset:
   - Stimulus: `start` and `stop` together in IDLE; `zero` while RUN; `clear` while RUN at 0x0037.
   - Response: state stays IDLE; `zero` has no effect in RUN; `clear` gives 0x0000, `running`=0 next cycle.
6. Lap (`STOPWATCH_LAP_EN`):
   - Stimulus: pulse `lap` at 0x0012; pulse `lap` while PAUSEd.
   - Response: `lap_digits`=0x0012 and held while `digits` advances; the PAUSE pulse is ignored; `zero` clears `lap_digits` to 0.
